// File: rtl/riscv_pkg.sv
// Shared definitions for the integer register file.
//   XLEN_DEFAULT : default data width
//   REG_AW()     : address width for a given register count
//   rf_state_t   : register-file lifecycle states (clear engine / normal run)
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  // Address width for nRegs registers; never less than one bit.
  function automatic int unsigned REG_AW(input int unsigned nRegs);
    return (nRegs < 2) ? 1 : $clog2(nRegs);
  endfunction

  typedef enum logic {
    RF_CLEAR,
    RF_RUN
  } rf_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard for issue-stage hazard checks.
//   clk, reset         : clock, synchronous active-high reset (clears all bits)
//   enable             : high while the register file is in normal operation
//   we0/waddr0         : ALU writeback, clears busy[waddr0]
//   we1/waddr1         : load writeback, clears busy[waddr1]
//   allocValid/Addr    : issue allocation, sets busy[allocAddr]
//   busy               : scoreboard bits, bit 0 always 0
module regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  localparam int unsigned AW = REG_AW(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             we0,
  input  logic [AW-1:0]    waddr0,
  input  logic             we1,
  input  logic [AW-1:0]    waddr1,
  input  logic             allocValid,
  input  logic [AW-1:0]    allocAddr,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busyQ, busyD;

  always_comb begin
    busyD = busyQ;
    if (enable) begin
      if (we0) busyD[waddr0] = 1'b0;
      if (we1) busyD[waddr1] = 1'b0;
      // Set after the clears: a new producer allocated in the same cycle wins.
      if (allocValid && (allocAddr != '0)) busyD[allocAddr] = 1'b1;
    end
    busyD[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busyQ <= '0;
    end else begin
      busyQ <= busyD;
    end
  end

  assign busy = busyQ;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with two prioritised write ports, optional
// same-cycle write-to-read bypass, a busy scoreboard and a post-reset clear engine.
//   clk, reset          : clock, synchronous active-high reset (restarts the clear)
//   raddr / rdata       : NREAD combinational read ports, port i at [i*AW] / [i*XLEN]
//   we0/waddr0/wdata0   : ALU writeback port
//   we1/waddr1/wdata1   : load writeback port, wins over port 0 on the same address
//   alloc_valid/addr    : marks a destination busy at issue
//   busy                : scoreboard bits, bit 0 always 0
//   ready               : clear finished, file usable
module regfile_mp
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NREAD  = 2,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned AW    = REG_AW(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [AW-1:0]         waddr0,
  input  logic [AW-1:0]         waddr1,
  input  logic [XLEN-1:0]       wdata0,
  input  logic [XLEN-1:0]       wdata1,
  input  logic                  alloc_valid,
  input  logic [AW-1:0]         alloc_addr,
  output logic [NREGS-1:0]      busy,
  output logic                  ready
);

  localparam logic [AW:0] lastReg  = (AW+1)'(NREGS - 1);
  localparam logic [AW:0] firstReg = (AW+1)'(1);

  rf_state_t   stateQ, stateD;
  // One bit wider than an address so the increment past NREGS-1 cannot alias.
  logic [AW:0] clrCntQ, clrCntD;

  logic running;
  logic clearing;
  logic wrEn0, wrEn1;

  // Entry 0 is never written; reads of address 0 are forced to zero instead.
  logic [XLEN-1:0] mem [NREGS];

  logic [AW-1:0]   rAddr;
  logic [XLEN-1:0] rVal;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ  <= RF_CLEAR;
      clrCntQ <= firstReg;
    end else begin
      stateQ  <= stateD;
      clrCntQ <= clrCntD;
    end
  end

  // Next-state logic
  always_comb begin
    stateD  = stateQ;
    clrCntD = clrCntQ;
    case (stateQ)
      RF_CLEAR: begin
        clrCntD = clrCntQ + firstReg;
        if (clrCntQ == lastReg) stateD = RF_RUN;
      end
      RF_RUN:  stateD = RF_RUN;
      default: stateD = RF_CLEAR;
    endcase
  end

  // Output logic
  always_comb begin
    running  = (stateQ == RF_RUN);
    clearing = (stateQ == RF_CLEAR);
    ready    = running;
  end

  // Writes to x0 are dropped here so neither the array nor the bypass sees them.
  assign wrEn0 = running && we0 && (waddr0 != '0);
  assign wrEn1 = running && we1 && (waddr1 != '0);

  // Array: port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clearing) begin
        mem[clrCntQ[AW-1:0]] <= '0;
      end else begin
        if (wrEn0) mem[waddr0] <= wdata0;
        if (wrEn1) mem[waddr1] <= wdata1;
      end
    end
  end

  // Read ports with optional same-cycle forwarding.
  always_comb begin
    rdata = '0;
    rAddr = '0;
    rVal  = '0;
    for (int i = 0; i < NREAD; i++) begin
      rAddr = raddr[i*AW +: AW];
      rVal  = mem[rAddr];
      if (BYPASS) begin
        if (wrEn0 && (waddr0 == rAddr)) rVal = wdata0;
        if (wrEn1 && (waddr1 == rAddr)) rVal = wdata1;
      end
      if (!running || (rAddr == '0)) rVal = '0;
      rdata[i*XLEN +: XLEN] = rVal;
    end
  end

  regfile_scoreboard #(
    .NREGS(NREGS)
  ) uScoreboard (
    .clk       (clk),
    .reset     (reset),
    .enable    (running),
    .we0       (we0),
    .waddr0    (waddr0),
    .we1       (we1),
    .waddr1    (waddr1),
    .allocValid(alloc_valid),
    .allocAddr (alloc_addr),
    .busy      (busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default 32x2 instance with bypass, an identical
// instance without bypass, and a 16-register 4-read-port instance.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the 32-register instances
  logic        reset;
  logic [9:0]  raddr;
  logic [63:0] rdata, rdataNb;
  logic        we0, we1;
  logic [4:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
  logic        allocValid;
  logic [4:0]  allocAddr;
  logic [31:0] busy, busyNb;
  logic        ready, readyNb;

  // Small instance stimulus
  logic         sReset;
  logic [15:0]  sRaddr;
  logic [127:0] sRdata;
  logic         sWe0, sWe1;
  logic [3:0]   sWaddr0, sWaddr1;
  logic [31:0]  sWdata0, sWdata1;
  logic         sAllocValid;
  logic [3:0]   sAllocAddr;
  logic [15:0]  sBusy;
  logic         sReady;

  int nTests = 0;
  int nFail  = 0;
  int mCnt, nbCnt, sCnt;

  regfile_mp dut (
    .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1), .alloc_valid(allocValid),
    .alloc_addr(allocAddr), .busy(busy), .ready(ready)
  );

  regfile_mp #(.BYPASS(1'b0)) dutNb (
    .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdataNb),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1), .alloc_valid(allocValid),
    .alloc_addr(allocAddr), .busy(busyNb), .ready(readyNb)
  );

  regfile_mp #(.NREGS(16), .NREAD(4)) dutSmall (
    .clk(clk), .reset(sReset), .raddr(sRaddr), .rdata(sRdata),
    .we0(sWe0), .we1(sWe1), .waddr0(sWaddr0), .waddr1(sWaddr1),
    .wdata0(sWdata0), .wdata1(sWdata1), .alloc_valid(sAllocValid),
    .alloc_addr(sAllocAddr), .busy(sBusy), .ready(sReady)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; allocValid = 1'b0;
    sWe0 = 1'b0; sWe1 = 1'b0; sAllocValid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sReset = 1'b1;
    idle();
    raddr = '0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; allocAddr = '0;
    sRaddr = '0; sWaddr0 = '0; sWaddr1 = '0; sWdata0 = '0; sWdata1 = '0; sAllocAddr = '0;

    // Reset state
    repeat (3) tick();
    check("rst_ready", 128'(ready), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_rdata", 128'(rdata), 128'd0);
    check("rst_sready", 128'(sReady), 128'd0);

    // Clear latency: count edges after release until ready
    reset = 1'b0; sReset = 1'b0;
    mCnt = 0; nbCnt = 0; sCnt = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (mCnt == 0 && ready) mCnt = i;
      if (nbCnt == 0 && readyNb) nbCnt = i;
      if (sCnt == 0 && sReady) sCnt = i;
    end
    check("clr_lat", 128'(mCnt), 128'd31);
    check("clr_lat_nb", 128'(nbCnt), 128'd31);
    check("clr_lat_small", 128'(sCnt), 128'd15);

    // Every register reads zero after the clear
    for (int r = 0; r < 32; r++) begin
      raddr = {5'(31 - r), 5'(r)};
      #1;
      check("zero_rd", 128'(rdata), 128'd0);
    end
    check("zero_busy", 128'(busy), 128'd0);

    // x5 write: bypassed same cycle only on the bypass instance
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; raddr = {5'd0, 5'd5};
    #2;
    check("byp_x5", 128'(rdata[31:0]), 128'hDEADBEEF);
    check("nobyp_x5", 128'(rdataNb[31:0]), 128'd0);
    tick(); idle(); #1;
    check("rd_x5", 128'(rdata[31:0]), 128'hDEADBEEF);
    check("rd_x5_nb", 128'(rdataNb[31:0]), 128'hDEADBEEF);

    // x0 write is dropped and never forwarded
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h1234; raddr = {5'd5, 5'd0};
    #2;
    check("x0_same", 128'(rdata), {64'd0, 32'hDEADBEEF, 32'd0});
    tick(); idle(); #1;
    check("x0_next", 128'(rdata[31:0]), 128'd0);
    check("x0_next_nb", 128'(rdataNb[31:0]), 128'd0);

    // Preload x7, then collide both ports on x7
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h55;
    tick(); idle();
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22; raddr = {5'd7, 5'd7};
    #2;
    check("pri_byp", 128'(rdata), {64'd0, 32'h22, 32'h22});
    check("pri_nobyp", 128'(rdataNb), {64'd0, 32'h55, 32'h55});
    tick(); idle(); #1;
    check("pri_next", 128'(rdata), {64'd0, 32'h22, 32'h22});
    check("pri_next_nb", 128'(rdataNb), {64'd0, 32'h22, 32'h22});

    // Port-0-only forward onto read port 1
    we0 = 1'b1; waddr0 = 5'd8; wdata0 = 32'h77; raddr = {5'd8, 5'd7};
    #2;
    check("byp_p1", 128'(rdata), {64'd0, 32'h77, 32'h22});
    check("nobyp_p1", 128'(rdataNb), {64'd0, 32'h0, 32'h22});
    tick(); idle(); #1;

    // Scoreboard
    allocValid = 1'b1; allocAddr = 5'd9;
    tick(); idle(); #1;
    check("sb_alloc", 128'(busy), 128'h200);
    allocValid = 1'b1; allocAddr = 5'd9; we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h99;
    tick(); idle(); #1;
    check("sb_alloc_wr1", 128'(busy), 128'h200);
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h9A; raddr = {5'd0, 5'd9};
    tick(); idle(); #1;
    check("sb_wr0_clear", 128'(busy), 128'd0);
    check("rd_x9", 128'(rdata[31:0]), 128'h9A);
    allocValid = 1'b1; allocAddr = 5'd0;
    tick(); idle(); #1;
    check("sb_alloc_x0", 128'(busy), 128'd0);
    allocValid = 1'b1; allocAddr = 5'd3; we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h3;
    tick(); idle(); #1;
    check("sb_alloc_wr0", 128'(busy), 128'h8);
    check("sb_nb_match", 128'(busyNb), 128'h8);
    we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h4;
    tick(); idle(); #1;
    check("sb_wr1_clear", 128'(busy), 128'd0);

    // Reset mid-run with a pending write, then a reset pulse at clear count 10
    reset = 1'b1; we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hBAD;
    tick();
    reset = 1'b0;
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hAAAA;
    we1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'hBBBB;
    allocValid = 1'b1; allocAddr = 5'd4; raddr = {5'd6, 5'd5};
    #2;
    check("clr_ready_low", 128'(ready), 128'd0);
    check("clr_rdata", 128'(rdata), 128'd0);
    repeat (9) tick();
    check("clr_mid_ready", 128'(ready), 128'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mCnt = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (ready) begin
        mCnt = i;
        break;
      end
    end
    idle();
    check("clr_restart_lat", 128'(mCnt), 128'd31);
    #1;
    check("drop_wr", 128'(rdata), 128'd0);
    check("drop_busy", 128'(busy), 128'd0);
    raddr = {5'd9, 5'd7};
    #1;
    check("clr_wiped", 128'(rdata), 128'd0);

    // Small instance: four concurrent reads
    sWe0 = 1'b1; sWaddr0 = 4'd3;  sWdata0 = 32'h33;
    sWe1 = 1'b1; sWaddr1 = 4'd12; sWdata1 = 32'hCC;
    tick();
    sWaddr0 = 4'd7;  sWdata0 = 32'h77;
    sWaddr1 = 4'd15; sWdata1 = 32'hFF;
    tick(); idle();
    sRaddr = {4'd15, 4'd12, 4'd7, 4'd3};
    #1;
    check("small_rd4", sRdata, {32'hFF, 32'hCC, 32'h77, 32'h33});
    sRaddr = {4'd3, 4'd0, 4'd15, 4'd7};
    #1;
    check("small_rd4_perm", sRdata, {32'h33, 32'h0, 32'hFF, 32'h77});
    sWe0 = 1'b1; sWaddr0 = 4'd2; sWdata0 = 32'h2222;
    sRaddr = {4'd3, 4'd2, 4'd15, 4'd7};
    #1;
    check("small_byp", sRdata, {32'h33, 32'h2222, 32'hFF, 32'h77});
    tick(); idle();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
